// File: rtl/sisc_pkg.sv
// Shared SISC definitions: instruction/address widths and the loader FSM states.
// Used by the program loader; pc, im and ir size themselves from the same widths.
// No logic, constants and types only.
package sisc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Byte packer: shifts stream bytes into a 32-bit word, first byte ends up in [31:24].
// Latency: word/last_byte reflect a shifted byte on the cycle after shift_en.
// Backpressure: none; the caller gates shift_en with its own handshake.
module byte_packer (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  // Shift register and byte position; clr discards any partial word at load start.
  always_ff @(posedge clk) begin
    if (rst_f || clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (shift_en) begin
      r_word <= {r_word[23:0], byte_in};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign word      = r_word;
  assign last_byte = (r_cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Program loader: packs a byte stream into 32-bit words and writes them to im from address 0.
// Latency: byte 3 accepted at edge M -> im_we high in cycle M+1; len words take 5*len+1 cycles.
// Backpressure: byte_ready is low outside RECV (including every WRITE cycle); stream gaps just stall.
module im_loader #(
  parameter int ADDR_W    = sisc_pkg::ADDR_W,
  parameter int INSTR_W   = sisc_pkg::INSTR_W,
  parameter int MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               start,
  input  logic [ADDR_W-1:0]  len,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [ADDR_W-1:0]  im_wr_addr,
  output logic [INSTR_W-1:0] im_wr_data,
  output logic               im_we,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  // Word counter only needs to reach MAX_WORDS; the address is its zero-extension.
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_WORDS);

  sisc_pkg::loader_state_t r_state;

  logic [ADDR_W-1:0]  r_len;
  logic [CNT_W-1:0]   r_word_cnt;
  logic               r_byte_ready;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [INSTR_W-1:0] r_wr_data;
  logic               r_we;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_len_ok;
  logic               w_start_ok;
  logic               w_accept;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_last_word;
  logic [31:0]        w_word;
  logic               w_last_byte;

  assign w_len_ok    = (len != '0) && ({1'b0, len} <= MAX_LEN);
  assign w_start_ok  = (r_state == sisc_pkg::IDLE) && start && w_len_ok;
  assign w_accept    = byte_valid && r_byte_ready;
  assign w_cnt_next  = r_word_cnt + CNT_W'(1);
  assign w_last_word = (ADDR_W'(w_cnt_next) == r_len);

  byte_packer u_packer (
    .clk       (clk),
    .rst_f     (rst_f),
    .clr       (w_start_ok),
    .shift_en  (w_accept),
    .byte_in   (byte_in),
    .word      (w_word),
    .last_byte (w_last_byte)
  );

  // Loader FSM; all outputs are registered and updated on the state transitions.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      r_state      <= sisc_pkg::IDLE;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_ready <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        sisc_pkg::IDLE: begin
          if (start) begin
            if (w_len_ok) begin
              r_len        <= len;
              r_word_cnt   <= '0;
              r_err        <= 1'b0;
              r_busy       <= 1'b1;
              r_byte_ready <= 1'b1;
              r_state      <= sisc_pkg::RECV;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        sisc_pkg::RECV: begin
          // The packer still holds bytes 0..2, so the final byte is merged here directly.
          if (w_accept && w_last_byte) begin
            r_byte_ready <= 1'b0;
            r_we         <= 1'b1;
            r_wr_addr    <= ADDR_W'(r_word_cnt);
            r_wr_data    <= INSTR_W'({w_word[23:0], byte_in});
            r_state      <= sisc_pkg::WRITE;
          end
        end
        sisc_pkg::WRITE: begin
          r_word_cnt <= w_cnt_next;
          if (w_last_word) begin
            r_done  <= 1'b1;
            r_state <= sisc_pkg::FINISH;
          end else begin
            r_byte_ready <= 1'b1;
            r_state      <= sisc_pkg::RECV;
          end
        end
        sisc_pkg::FINISH: begin
          // busy/cpu_hold drop together with done so the CPU fetches a complete program.
          r_busy  <= 1'b0;
          r_state <= sisc_pkg::IDLE;
        end
        default: r_state <= sisc_pkg::IDLE;
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign im_wr_addr = r_wr_addr;
  assign im_wr_data = r_wr_data;
  assign im_we      = r_we;
  assign busy       = r_busy;
  assign cpu_hold   = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
